// File: rtl/ws2812_rx_decoder.sv
`timescale 1ns/1ps
// ws2812_rx_decoder
// Decodes a WS2812 single-wire NRZ pixel stream (GRB, 24 bit/pixel, MSB first)
// back into words. It measures high/low pulse widths on the synchronised line,
// assembles words, detects latch gaps and flags protocol errors.
//
// Ports
//   Clk        in   1       system clock, rising edge
//   aReset     in   1       asynchronous reset, active low
//   Din        in   1       raw serial line, asynchronous to Clk
//   DataOut    out  NBBITS  last complete word, MSB = first bit received
//   DataValid  out  1       one-cycle strobe, DataOut valid in same cycle
//   PixIdx     out  8       index of the word in DataOut within its frame
//   FrameEnd   out  1       one-cycle strobe on a latch gap after received data
//   Busy       out  1       high while inside a bit (HIGH or LOW state)
//   ErrPulse   out  1       one-cycle strobe on any protocol error
//   ErrClr     in   1       synchronous clear of ErrCnt        (WS2812_RX_ERRCNT_EN)
//   ErrCnt     out  8       saturating error counter           (WS2812_RX_ERRCNT_EN)
//
// Optional feature macro: WS2812_RX_ERRCNT_EN adds ErrClr/ErrCnt.
module ws2812_rx_decoder #(
    parameter int NBBITS   = 24,
    parameter int CNT_BITS = 12,
    parameter int MIN_HIGH = 8,
    parameter int THRESH   = 30,
    parameter int MAX_HIGH = 60,
    parameter int RST_CYC  = 2500
) (
    input  logic              Clk,
    input  logic              aReset,
    input  logic              Din,
`ifdef WS2812_RX_ERRCNT_EN
    input  logic              ErrClr,
    output logic [7:0]        ErrCnt,
`endif
    output logic [NBBITS-1:0] DataOut,
    output logic              DataValid,
    output logic [7:0]        PixIdx,
    output logic              FrameEnd,
    output logic              Busy,
    output logic              ErrPulse
);

    localparam int BC_W = $clog2(NBBITS + 1);
    localparam logic [CNT_BITS-1:0] L_MIN = CNT_BITS'(MIN_HIGH);
    localparam logic [CNT_BITS-1:0] L_THR = CNT_BITS'(THRESH);
    localparam logic [CNT_BITS-1:0] L_MAX = CNT_BITS'(MAX_HIGH);
    localparam logic [CNT_BITS-1:0] L_RST = CNT_BITS'(RST_CYC);
    localparam logic [BC_W-1:0]     L_NB  = BC_W'(NBBITS);

    typedef enum logic [1:0] {S_WAIT_GAP, S_IDLE, S_HIGH, S_LOW} state_t;

    state_t              r_state, w_next;
    logic                r_sync1, r_sync2, r_dly;
    logic [CNT_BITS-1:0] r_cnt, w_cnt_inc;
    logic [BC_W-1:0]     r_bitcnt;
    logic [7:0]          r_idx;
    logic [NBBITS-1:0]   r_shift;
    logic w_rise, w_fall, w_glitch, w_stuck, w_shift, w_gap, w_partial, w_frame_end, w_err;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge Clk or negedge aReset) begin
        if (!aReset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= Din;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    assign w_rise    = r_sync2 & ~r_dly;
    assign w_fall    = ~r_sync2 & r_dly;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // State register
    always_ff @(posedge Clk or negedge aReset) begin
        if (!aReset) r_state <= S_WAIT_GAP;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_WAIT_GAP: if (r_cnt >= L_RST) w_next = S_IDLE;
            S_IDLE:     if (w_rise) w_next = S_HIGH;
            S_HIGH: begin
                if (w_glitch || w_stuck) w_next = S_WAIT_GAP;
                else if (w_fall)         w_next = S_LOW;
            end
            S_LOW: begin
                if (w_rise)     w_next = S_HIGH;
                else if (w_gap) w_next = S_IDLE;  // gap already seen, no second wait
            end
            default: w_next = S_WAIT_GAP;
        endcase
    end

    // Output/strobe decode
    always_comb begin
        w_glitch    = (r_state == S_HIGH) && w_fall && (r_cnt < L_MIN);
        // A pulse that reached MAX_HIGH is an error even if it ends this cycle.
        w_stuck     = (r_state == S_HIGH) && (r_cnt >= L_MAX);
        w_shift     = (r_state == S_HIGH) && w_fall && !w_glitch && !w_stuck;
        w_gap       = (r_state == S_LOW) && !w_rise && (r_cnt >= L_RST);
        w_partial   = w_gap && (r_bitcnt != '0);
        w_frame_end = w_gap && ((r_bitcnt != '0) || (r_idx != 8'd0));
        w_err       = w_glitch || w_stuck || w_partial;
    end

    assign Busy = (r_state == S_HIGH) || (r_state == S_LOW);

    // Pulse-width counter: low cycles in WAIT_GAP/LOW, high cycles in HIGH.
    always_ff @(posedge Clk or negedge aReset) begin
        if (!aReset) begin
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                S_WAIT_GAP: r_cnt <= r_sync2 ? '0 : w_cnt_inc;
                S_IDLE:     r_cnt <= CNT_BITS'(1);
                S_HIGH: begin
                    if (w_glitch || w_stuck) r_cnt <= '0;
                    else if (w_fall)         r_cnt <= CNT_BITS'(1);
                    else                     r_cnt <= w_cnt_inc;
                end
                S_LOW:      r_cnt <= w_rise ? CNT_BITS'(1) : w_cnt_inc;
                default:    r_cnt <= '0;
            endcase
        end
    end

    // Word assembly. Completion runs the cycle after the last bit is shifted,
    // so it can never coincide with a shift (the next high pulse needs time).
    always_ff @(posedge Clk or negedge aReset) begin
        if (!aReset) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            r_idx     <= 8'd0;
            DataOut   <= '0;
            DataValid <= 1'b0;
            PixIdx    <= 8'd0;
            FrameEnd  <= 1'b0;
            ErrPulse  <= 1'b0;
        end else begin
            DataValid <= 1'b0;
            FrameEnd  <= w_frame_end;
            ErrPulse  <= w_err;
            if (w_err) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
                r_idx    <= 8'd0;
            end else begin
                if (w_shift) begin
                    r_shift  <= {r_shift[NBBITS-2:0], (r_cnt >= L_THR)};
                    r_bitcnt <= r_bitcnt + 1'b1;
                end else if (r_bitcnt == L_NB) begin
                    DataOut   <= r_shift;
                    DataValid <= 1'b1;
                    PixIdx    <= r_idx;
                    r_idx     <= r_idx + 8'd1;
                    r_bitcnt  <= '0;
                end
                if (w_gap) r_idx <= 8'd0;
            end
        end
    end

`ifdef WS2812_RX_ERRCNT_EN
    // Clear has priority over a same-cycle increment.
    always_ff @(posedge Clk or negedge aReset) begin
        if (!aReset)                        ErrCnt <= 8'd0;
        else if (ErrClr)                    ErrCnt <= 8'd0;
        else if (ErrPulse && ErrCnt != 8'hFF) ErrCnt <= ErrCnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
`timescale 1ns/1ps
// Bench for ws2812_rx_decoder: drives NRZ pulses on Din, a scoreboard queue
// holds expected words, a negedge monitor pops and compares on DataValid.
module tb_ws2812_rx_decoder;
`ifdef WS2812_RX_ERRCNT_EN
    localparam int RST = 100;   // short gaps keep the 300-error loop quick
`else
    localparam int RST = 2500;
`endif

    logic        Clk = 1'b0, aReset = 1'b0, Din = 1'b0;
    logic [23:0] DataOut;
    logic        DataValid, FrameEnd, Busy, ErrPulse;
    logic [7:0]  PixIdx;
`ifdef WS2812_RX_ERRCNT_EN
    logic        ErrClr = 1'b0;
    logic [7:0]  ErrCnt;
`endif

    ws2812_rx_decoder #(.RST_CYC(RST)) dut (
        .Clk(Clk), .aReset(aReset), .Din(Din),
`ifdef WS2812_RX_ERRCNT_EN
        .ErrClr(ErrClr), .ErrCnt(ErrCnt),
`endif
        .DataOut(DataOut), .DataValid(DataValid), .PixIdx(PixIdx),
        .FrameEnd(FrameEnd), .Busy(Busy), .ErrPulse(ErrPulse)
    );

    always #10 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct { logic [23:0] data; logic [7:0] idx; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0, n_fail = 0;
    int dv_n = 0, fe_n = 0, er_n = 0;
    int dv_cyc = 0, fe_cyc = 0, er_cyc = 0, last_fall = 0;
    logic [7:0]  exp_idx = 8'd0;
    logic [23:0] last_good = 24'd0;

    always @(negedge Clk) begin
        if (DataValid) begin
            dv_n++;
            dv_cyc = cyc;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL dv_unexpected: DataOut=%h PixIdx=%0d, required no word", DataOut, PixIdx);
            end else begin
                mon_e = sb.pop_front();
                if (DataOut !== mon_e.data || PixIdx !== mon_e.idx) begin
                    n_fail++;
                    $display("FAIL word: DataOut=%h PixIdx=%0d, required %h/%0d",
                             DataOut, PixIdx, mon_e.data, mon_e.idx);
                end
            end
        end
        if (FrameEnd) begin fe_n++; fe_cyc = cyc; end
        if (ErrPulse) begin er_n++; er_cyc = cyc; end
    end

    // High for h cycles then low for lo cycles; starts/ends at posedge+1.
    task automatic pulse(input int h, input int lo);
        Din = 1'b1;
        repeat (h) @(posedge Clk);
        #1 Din = 1'b0;
        last_fall = cyc;
        repeat (lo) @(posedge Clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(40, 22);
        else   pulse(20, 42);
    endtask

    task automatic send_word(input logic [23:0] d, input bit expect_it);
        exp_t e;
        if (expect_it) begin
            e.data = d; e.idx = exp_idx;
            sb.push_back(e);
            exp_idx++;
            last_good = d;
        end
        for (int i = 23; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic gap();
        Din = 1'b0;
        repeat (RST + 50) @(posedge Clk);
        #1;
        exp_idx = 8'd0;
    endtask

    task automatic test_reset();
        aReset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_cmp++; if (DataOut !== 24'd0) begin n_fail++; $display("FAIL rst_dataout: got %h, required 0", DataOut); end
        n_cmp++; if (DataValid !== 1'b0 || FrameEnd !== 1'b0 || ErrPulse !== 1'b0) begin
            n_fail++; $display("FAIL rst_strobes: got %b%b%b, required 000", DataValid, FrameEnd, ErrPulse); end
        n_cmp++; if (Busy !== 1'b0 || PixIdx !== 8'd0) begin
            n_fail++; $display("FAIL rst_busy_idx: got %b/%0d, required 0/0", Busy, PixIdx); end
        aReset = 1'b1;
        repeat (RST + 20) @(posedge Clk);
        #1;
    endtask

    task automatic test_single();
        int d0, f0, e0;
        d0 = dv_n; f0 = fe_n; e0 = er_n;
        send_word(24'hA53CF0, 1);
        n_cmp++; if (dv_n - d0 !== 1) begin n_fail++; $display("FAIL single_count: got %0d words, required 1", dv_n - d0); end
        n_cmp++; if (dv_cyc - last_fall !== 4) begin n_fail++; $display("FAIL single_latency: got %0d cycles, required 4", dv_cyc - last_fall); end
        n_cmp++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL busy_low: got %b, required 1", Busy); end
        gap();
        n_cmp++; if (fe_n - f0 !== 1 || er_n - e0 !== 0) begin
            n_fail++; $display("FAIL single_gap: got fe=%0d err=%0d, required 1/0", fe_n - f0, er_n - e0); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle: got %b, required 0", Busy); end
    endtask

    task automatic test_frame3();
        int d0, f0;
        d0 = dv_n; f0 = fe_n;
        send_word(24'h123456, 1);
        send_word(24'hFF0001, 1);
        send_word(24'h00FF80, 1);
        gap();
        n_cmp++; if (dv_n - d0 !== 3 || fe_n - f0 !== 1) begin
            n_fail++; $display("FAIL frame3: got dv=%0d fe=%0d, required 3/1", dv_n - d0, fe_n - f0); end
        send_word(24'h7E7E7E, 1);   // new frame restarts at PixIdx 0
        gap();
    endtask

    task automatic test_boundary();
        int d0, e0;
        exp_t e;
        logic [19:0] tail;
        d0 = dv_n; e0 = er_n;
        tail = 20'hC35A1;
        e.data = {4'b0011, tail}; e.idx = exp_idx;
        sb.push_back(e); exp_idx++; last_good = e.data;
        pulse(8, 54);    // shortest legal pulse -> 0
        pulse(29, 33);   // just below threshold -> 0
        pulse(30, 32);   // at threshold -> 1
        pulse(59, 3);    // one short of stuck -> 1
        for (int i = 19; i >= 0; i--) send_bit(tail[i]);
        gap();
        n_cmp++; if (dv_n - d0 !== 1 || er_n - e0 !== 0) begin
            n_fail++; $display("FAIL boundary: got dv=%0d err=%0d, required 1/0", dv_n - d0, er_n - e0); end
    endtask

    task automatic test_glitch();
        int d0, e0;
        d0 = dv_n; e0 = er_n;
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        pulse(5, 57);
        send_word(24'h111111, 0);
        send_word(24'h222222, 0);
        n_cmp++; if (er_n - e0 !== 1 || dv_n - d0 !== 0) begin
            n_fail++; $display("FAIL glitch: got err=%0d dv=%0d, required 1/0", er_n - e0, dv_n - d0); end
        gap();
        send_word(24'h5AA55A, 1);
        gap();
        n_cmp++; if (dv_n - d0 !== 1) begin n_fail++; $display("FAIL glitch_recover: got dv=%0d, required 1", dv_n - d0); end
    endtask

    task automatic test_stuck();
        int e0;
        e0 = er_n;
        pulse(60, 10);
        n_cmp++; if (er_n - e0 !== 1) begin n_fail++; $display("FAIL stuck_err: got %0d, required 1", er_n - e0); end
        n_cmp++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL stuck_state: Busy=%b, required 0", Busy); end
        gap();
    endtask

    task automatic test_partial();
        int d0, e0, f0;
        d0 = dv_n; e0 = er_n; f0 = fe_n;
        for (int i = 0; i < 10; i++) send_bit(i[1]);
        gap();
        n_cmp++; if (er_n - e0 !== 1 || fe_n - f0 !== 1) begin
            n_fail++; $display("FAIL partial_pulses: got err=%0d fe=%0d, required 1/1", er_n - e0, fe_n - f0); end
        n_cmp++; if (er_cyc !== fe_cyc) begin n_fail++; $display("FAIL partial_same_cycle: err@%0d fe@%0d, required equal", er_cyc, fe_cyc); end
        n_cmp++; if (dv_n - d0 !== 0 || DataOut !== last_good) begin
            n_fail++; $display("FAIL partial_data: got dv=%0d DataOut=%h, required 0/%h", dv_n - d0, DataOut, last_good); end
    endtask

    task automatic test_reset_mid();
        int d0;
        for (int i = 0; i < 11; i++) send_bit(1'b1);
        Din = 1'b1;
        repeat (5) @(posedge Clk);
        #1 aReset = 1'b0;
        #1;
        n_cmp++; if (DataOut !== 24'd0 || Busy !== 1'b0 || PixIdx !== 8'd0) begin
            n_fail++; $display("FAIL rstmid: got %h/%b/%0d, required 0/0/0", DataOut, Busy, PixIdx); end
`ifdef WS2812_RX_ERRCNT_EN
        n_cmp++; if (ErrCnt !== 8'd0) begin n_fail++; $display("FAIL rstmid_errcnt: got %0d, required 0", ErrCnt); end
`endif
        Din = 1'b0;
        repeat (2) @(posedge Clk);
        #1 aReset = 1'b1;
        exp_idx = 8'd0;
        repeat (RST + 20) @(posedge Clk);
        #1;
        d0 = dv_n;
        send_word(24'hC0FFEE, 1);
        gap();
        n_cmp++; if (dv_n - d0 !== 1) begin n_fail++; $display("FAIL rstmid_recover: got dv=%0d, required 1", dv_n - d0); end
    endtask

`ifdef WS2812_RX_ERRCNT_EN
    task automatic test_errcnt();
        for (int i = 0; i < 300; i++) begin
            pulse(5, RST + 20);
            if (i == 4) begin
                n_cmp++; if (ErrCnt !== 8'd5) begin n_fail++; $display("FAIL errcnt_5: got %0d, required 5", ErrCnt); end
            end
        end
        n_cmp++; if (ErrCnt !== 8'd255) begin n_fail++; $display("FAIL errcnt_sat: got %0d, required 255", ErrCnt); end
        ErrClr = 1'b1;
        @(posedge Clk);
        #1 ErrClr = 1'b0;
        n_cmp++; if (ErrCnt !== 8'd0) begin n_fail++; $display("FAIL errcnt_clr: got %0d, required 0", ErrCnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_frame3();
        test_boundary();
        test_glitch();
        test_stuck();
        test_partial();
        test_reset_mid();
`ifdef WS2812_RX_ERRCNT_EN
        test_errcnt();
`endif
        repeat (5) @(posedge Clk);
        #1;
        n_cmp++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drain: %0d words pending, required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
